// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, requester ids, full-word lane mask.
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D} bus_state_t;
  typedef enum logic {PORT_IF, PORT_D} bus_port_t;
  localparam logic [3:0] BE_WORD = 4'hF;
endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Requester handshakes plus the Avalon master pins of the CPU bus arbiter.
interface mips_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  // master: the arbiter itself (it is the Avalon master); slave: core + memory side
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata, busy,
           address, read, write, writedata, byteenable
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata, busy,
           address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon master between fetch and load/store; one transfer in flight,
// alternating priority on contention, registered read data per port.
module mips_bus_arbiter
  import mips_bus_pkg::*;
(
  input logic              clk,
  input logic              reset,
  mips_bus_arbiter_if.master bus
);
  bus_state_t state;
  bus_port_t  prio;
  logic       if_win, d_win, if_gnt_c, d_gnt_c, xfer_ok;

  always_comb begin
    if_win   = bus.if_req & (~bus.d_req | (prio == PORT_IF));
    d_win    = bus.d_req & ~if_win;
    if_gnt_c = ~reset & (state == IDLE) & if_win;
    d_gnt_c  = ~reset & (state == IDLE) & d_win;
    // A zero-lane write has neither strobe up, so it completes on its first bus cycle.
    xfer_ok  = (state != IDLE) & (~(bus.read | bus.write) | ~bus.waitrequest);
  end

  assign bus.if_gnt = if_gnt_c;
  assign bus.d_gnt  = d_gnt_c;
  assign bus.busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prio           <= PORT_IF;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
      bus.if_done    <= 1'b0;
      bus.d_done     <= 1'b0;
      bus.if_rdata   <= '0;
      bus.d_rdata    <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt_c) begin
            state          <= BUS_IF;
            prio           <= PORT_D;
            bus.address    <= bus.if_addr & ~32'h3;
            bus.read       <= 1'b1;
            bus.write      <= 1'b0;
            bus.writedata  <= '0;
            bus.byteenable <= BE_WORD;
          end else if (d_gnt_c) begin
            state          <= BUS_D;
            prio           <= PORT_IF;
            bus.address    <= bus.d_addr & ~32'h3;
            bus.read       <= ~bus.d_we;
            bus.write      <= bus.d_we & (bus.d_be != 4'h0);
            bus.writedata  <= bus.d_wdata;
            bus.byteenable <= bus.d_be;
          end
        end
        default: begin
          if (xfer_ok) begin
            state     <= IDLE;
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            if (state == BUS_IF) begin
              bus.if_done <= 1'b1;
              if (bus.read) bus.if_rdata <= bus.readdata;
            end else begin
              bus.d_done <= 1'b1;
              if (bus.read) bus.d_rdata <= bus.readdata;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench: table of single transfers run back to back, then reset-abort and contention sequences.
module tb_mips_bus_arbiter;
  logic clk, reset;
  int   total, bad;

  mips_bus_arbiter_if bus();
  mips_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] bus_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    bit          exp_rd;
    bit          exp_wr;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Starts in the low phase of a cycle in which the arbiter is IDLE; returns in the done cycle.
  task automatic run_vec(input int i, input vec_t v);
    bus.if_req      = !v.is_d;
    bus.if_addr     = v.addr;
    bus.d_req       = v.is_d;
    bus.d_we        = v.we;
    bus.d_addr      = v.addr;
    bus.d_wdata     = v.wdata;
    bus.d_be        = v.be;
    bus.readdata    = v.bus_rdata;
    bus.waitrequest = (v.waits > 0);
    #1;
    chk($sformatf("v%0d_if_gnt", i), 32'(bus.if_gnt), 32'(!v.is_d));
    chk($sformatf("v%0d_d_gnt", i), 32'(bus.d_gnt), 32'(v.is_d));
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    for (int k = 0; k <= v.waits; k++) begin
      bus.waitrequest = (k < v.waits);
      #1;
      chk($sformatf("v%0d_c%0d_read", i, k), 32'(bus.read), 32'(v.exp_rd));
      chk($sformatf("v%0d_c%0d_write", i, k), 32'(bus.write), 32'(v.exp_wr));
      chk($sformatf("v%0d_c%0d_addr", i, k), bus.address, v.exp_addr);
      chk($sformatf("v%0d_c%0d_be", i, k), 32'(bus.byteenable), 32'(v.exp_be));
      if (v.exp_wr) chk($sformatf("v%0d_c%0d_wdata", i, k), bus.writedata, v.wdata);
      chk($sformatf("v%0d_c%0d_gnt_busy_done", i, k),
          32'({bus.if_gnt, bus.d_gnt, bus.busy, bus.if_done, bus.d_done}), 32'b00100);
      @(negedge clk);
    end
    bus.waitrequest = 1'b0;
    #1;
    chk($sformatf("v%0d_if_done", i), 32'(bus.if_done), 32'(!v.is_d));
    chk($sformatf("v%0d_d_done", i), 32'(bus.d_done), 32'(v.is_d));
    chk($sformatf("v%0d_idle", i), 32'({bus.busy, bus.read, bus.write}), 32'b000);
    chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, v.exp_if_rdata);
    chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, v.exp_d_rdata);
  endtask

  initial begin
    int if_cnt, d_cnt;
    total = 0; bad = 0;
    vt[0] = '{0, 0, 32'hBFC0_0002, 32'h0,         4'h0, 0, 32'h2402_0005,
              32'hBFC0_0000, 4'hF, 1, 0, 32'h2402_0005, 32'h0};
    vt[1] = '{1, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 3, 32'hFFFF_0000,
              32'h0000_1004, 4'h3, 0, 1, 32'h2402_0005, 32'h0};
    vt[2] = '{1, 0, 32'h0000_2003, 32'h0,         4'hF, 1, 32'h1234_5678,
              32'h0000_2000, 4'hF, 1, 0, 32'h2402_0005, 32'h1234_5678};
    vt[3] = '{1, 1, 32'h0000_3000, 32'h0BAD_CAFE, 4'hC, 0, 32'hAAAA_AAAA,
              32'h0000_3000, 4'hC, 0, 1, 32'h2402_0005, 32'h1234_5678};
    vt[4] = '{1, 1, 32'h0000_3008, 32'h5555_5555, 4'h0, 0, 32'hBBBB_BBBB,
              32'h0000_3008, 4'h0, 0, 0, 32'h2402_0005, 32'h1234_5678};
    vt[5] = '{0, 0, 32'h0040_0009, 32'h0,         4'h0, 2, 32'h8C01_0004,
              32'h0040_0008, 4'hF, 1, 0, 32'h8C01_0004, 32'h1234_5678};
    vt[6] = '{1, 0, 32'h0000_0005, 32'h0,         4'h1, 0, 32'hCAFE_F00D,
              32'h0000_0004, 4'h1, 1, 0, 32'h8C01_0004, 32'hCAFE_F00D};

    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0; bus.waitrequest = 0; bus.readdata = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ctrl", 32'({bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.busy, bus.read, bus.write}), 32'h0);
    chk("rst_addr", bus.address, 32'h0);
    chk("rst_wdata", bus.writedata, 32'h0);
    chk("rst_be", 32'(bus.byteenable), 32'h0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Reset during a stalled data read: strobe drops, no done, read data cleared.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_4000; bus.d_be = 4'hF;
    bus.waitrequest = 1;
    #1 chk("rm_gnt", 32'(bus.d_gnt), 32'h1);
    @(negedge clk);
    bus.d_req = 0;
    #1 chk("rm_read_up", 32'(bus.read), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rm_read", 32'(bus.read), 32'h0);
    chk("rm_busy", 32'(bus.busy), 32'h0);
    chk("rm_done", 32'(bus.d_done), 32'h0);
    chk("rm_rdata", bus.d_rdata, 32'h0);
    reset = 1'b0;
    bus.waitrequest = 0;
    @(negedge clk);
    #1 chk("rm_after", 32'({bus.d_done, bus.if_done, bus.read, bus.busy}), 32'h0);

    // Contention from reset state: fetch first, then strict alternation.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0200; bus.d_be = 4'hF;
    bus.readdata = 32'h1111_2222;
    if_cnt = 0; d_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if_cnt += int'(bus.if_gnt);
      d_cnt  += int'(bus.d_gnt);
      chk($sformatf("ct%0d_gnt", t), 32'({bus.if_gnt, bus.d_gnt}), (t % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("ct%0d_done", t), 32'({bus.if_done, bus.d_done}),
          (t == 0) ? 32'b00 : ((t % 2 == 1) ? 32'b10 : 32'b01));
      @(negedge clk);
      #1;
      chk($sformatf("ct%0d_bus_gnt", t), 32'({bus.if_gnt, bus.d_gnt, bus.read}), 32'b001);
      chk($sformatf("ct%0d_addr", t), bus.address, (t % 2 == 0) ? 32'h100 : 32'h200);
      @(negedge clk);
    end
    bus.if_req = 0; bus.d_req = 0;
    #1;
    chk("ct_last_done", 32'({bus.if_done, bus.d_done}), 32'b01);
    chk("ct_if_cnt", 32'(if_cnt), 32'd5);
    chk("ct_d_cnt", 32'(d_cnt), 32'd5);
    chk("ct_rdata", bus.if_rdata ^ bus.d_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
